gpu_ci_initiator: RTL and testbench
===================================

GPU_CI_INITIATOR -- requirements
Module: gpu_ci_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the maximum cycles from command issue to response capture; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on clk.
REQ-004 core_req_valid  input  1  core issues a CUSTOM-0 command.
REQ-005 core_req_ready  output  1  initiator accepts a core command.
REQ-006 core_op  input  8  command opcode.
REQ-007 core_arg0, core_arg1  input  64 each  command operands.
REQ-008 core_rsp_valid  output  1  result available to core.
REQ-009 core_rsp_data  output  64  result word.
REQ-010 core_rsp_err  output  1  result is an error code, not GPU data.
REQ-011 core_rsp_ready  input  1  core accepts result.
REQ-012 ci_valid  output  1  command valid toward GPU CI responder.
REQ-013 ci_op  output  8; ci_arg0, ci_arg1  output  64 each  latched command fields.
REQ-014 ci_ready  input  1  responder accepts command.
REQ-015 ci_rsp_valid  input  1; ci_rsp_data  input  64  responder result.
REQ-016 ci_rsp_ready  output  1  initiator accepts responder result.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT_RSP, DONE; one transaction outstanding at a time.
REQ-019 IDLE: core_req_ready=1; on core_req_valid, latch core_op/arg0/arg1 into registers, clear timeout counter, next state REQ.
REQ-020 REQ: ci_valid=1 with latched fields; fields SHALL stay stable until ci_ready; on ci_valid&&ci_ready, next state WAIT_RSP.
REQ-021 ci_valid SHALL be 0 in every state other than REQ, so an always-ready responder sees exactly one valid cycle per command.
REQ-022 WAIT_RSP: ci_rsp_ready=1; on ci_rsp_valid, capture ci_rsp_data into core_rsp_data, next state DONE.
REQ-023 core_rsp_err SHALL be 1 when captured data equals 64'hDEAD_DEAD_DEAD_0001 (responder not connected), else 0.
REQ-024 DONE: core_rsp_valid=1, data/err stable; on core_rsp_ready, next state IDLE.
REQ-025 Timeout counter (16 bit) SHALL increment each cycle in REQ and WAIT_RSP; when it reaches TIMEOUT_CYCLES-1 without the state's completing handshake, next state DONE with core_rsp_data=64'hDEAD_DEAD_DEAD_0002, core_rsp_err=1.
REQ-026 Handshake and timeout in the same cycle: handshake SHALL win.
REQ-027 IDLE: ci_rsp_ready=1 so a late response from a timed-out command is drained and discarded without changing outputs.
REQ-028 Minimum latency with always-ready responder and core: accept (cycle 0), ci_valid (1), rsp capture (2), core_rsp_valid (3).
REQ-029 core_req_ready SHALL be 0 outside IDLE; back-to-back commands SHALL each complete in order.

Reset
REQ-030 While rst=1: state IDLE, core_rsp_valid=0, core_rsp_data=0, core_rsp_err=0, ci_valid=0, ci_op=0, ci_arg0=0, ci_arg1=0, busy=0, counter=0.
REQ-031 rst asserted mid-transaction SHALL abandon it with no core response; first cycle after rst deasserts, core_req_ready=1.

Verification
REQ-032 Always-ready responder returning 64'h1234 one cycle after command, op=8'h05 -> ci_valid high exactly 1 cycle with op 05; core_rsp_valid at cycle 3, data 64'h1234, err=0.
REQ-033 Responder holds ci_ready=0 for 5 cycles -> ci_valid and fields stable all 5 cycles; completion delayed 5 cycles.
REQ-034 Stub-style responder returning 64'hDEAD_DEAD_DEAD_0001 -> core_rsp_err=1, data passed unchanged.
REQ-035 TIMEOUT_CYCLES=8, responder never asserts ci_rsp_valid -> DONE after 8 cycles in REQ/WAIT_RSP, data 64'hDEAD_DEAD_DEAD_0002, err=1; late rsp in IDLE discarded.
REQ-036 core_rsp_ready held 0 for 4 cycles -> core_rsp_valid/data stable; new core_req_valid not accepted until return to IDLE.
REQ-037 rst pulsed while in WAIT_RSP -> all outputs at reset values next cycle; next command completes normally.

Source files
------------

// File: rtl/gpu_ci_initiator.sv
// GPU command-interface initiator: accepts one CUSTOM-0 command from the core,
// forwards it to the GPU CI responder, waits for the result (with timeout) and
// hands the result back to the core. One transaction in flight at a time.
module gpu_ci_initiator #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    // core side
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic [7:0]  core_op,
    input  logic [63:0] core_arg0,
    input  logic [63:0] core_arg1,
    output logic        core_rsp_valid,
    output logic [63:0] core_rsp_data,
    output logic        core_rsp_err,
    input  logic        core_rsp_ready,
    // GPU CI responder side
    output logic        ci_valid,
    output logic [7:0]  ci_op,
    output logic [63:0] ci_arg0,
    output logic [63:0] ci_arg1,
    input  logic        ci_ready,
    input  logic        ci_rsp_valid,
    input  logic [63:0] ci_rsp_data,
    output logic        ci_rsp_ready,
    output logic        busy
);

    // Responder-absent marker returned by a stub responder.
    localparam logic [63:0] RSP_NOT_CONNECTED = 64'hDEAD_DEAD_DEAD_0001;
    // Result word substituted when the responder fails to answer in time.
    localparam logic [63:0] RSP_TIMEOUT       = 64'hDEAD_DEAD_DEAD_0002;
    // Last counter value before the transaction is abandoned.
    localparam logic [15:0] CNT_LAST          = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [63:0] arg0_q, arg0_d;
    logic [63:0] arg1_q, arg1_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    // State and datapath registers; reset clears everything visible to either side.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            arg0_q     <= '0;
            arg1_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            arg0_q     <= arg0_d;
            arg1_q     <= arg1_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next-state logic: handshakes are tested before the timeout so a
    // completion on the last allowed cycle still counts as success.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        arg0_d     = arg0_q;
        arg1_d     = arg1_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (core_req_valid) begin
                    op_d    = core_op;
                    arg0_d  = core_arg0;
                    arg1_d  = core_arg1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (ci_ready) begin
                    state_d = WAIT_RSP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = RSP_TIMEOUT;
                    rsp_err_d  = 1'b1;
                    state_d    = DONE;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + 16'd1;
                if (ci_rsp_valid) begin
                    rsp_data_d = ci_rsp_data;
                    rsp_err_d  = (ci_rsp_data == RSP_NOT_CONNECTED);
                    state_d    = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = RSP_TIMEOUT;
                    rsp_err_d  = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (core_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: handshake strobes depend only on state; data comes from registers.
    always_comb begin
        core_req_ready = (state_q == IDLE);
        ci_valid       = (state_q == REQ);
        // IDLE also accepts responses so a late answer to a timed-out command is drained.
        ci_rsp_ready   = (state_q == WAIT_RSP) || (state_q == IDLE);
        core_rsp_valid = (state_q == DONE);
        busy           = (state_q != IDLE);
        ci_op          = op_q;
        ci_arg0        = arg0_q;
        ci_arg1        = arg1_q;
        core_rsp_data  = rsp_data_q;
        core_rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_gpu_ci_initiator.sv
// Directed self-checking bench for gpu_ci_initiator (TIMEOUT_CYCLES = 8).
module tb_gpu_ci_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_valid;
    logic        core_req_ready;
    logic [7:0]  core_op;
    logic [63:0] core_arg0;
    logic [63:0] core_arg1;
    logic        core_rsp_valid;
    logic [63:0] core_rsp_data;
    logic        core_rsp_err;
    logic        core_rsp_ready;
    logic        ci_valid;
    logic [7:0]  ci_op;
    logic [63:0] ci_arg0;
    logic [63:0] ci_arg1;
    logic        ci_ready;
    logic        ci_rsp_valid;
    logic [63:0] ci_rsp_data;
    logic        ci_rsp_ready;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int n;

    gpu_ci_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .core_req_valid(core_req_valid),
        .core_req_ready(core_req_ready),
        .core_op       (core_op),
        .core_arg0     (core_arg0),
        .core_arg1     (core_arg1),
        .core_rsp_valid(core_rsp_valid),
        .core_rsp_data (core_rsp_data),
        .core_rsp_err  (core_rsp_err),
        .core_rsp_ready(core_rsp_ready),
        .ci_valid      (ci_valid),
        .ci_op         (ci_op),
        .ci_arg0       (ci_arg0),
        .ci_arg1       (ci_arg1),
        .ci_ready      (ci_ready),
        .ci_rsp_valid  (ci_rsp_valid),
        .ci_rsp_data   (ci_rsp_data),
        .ci_rsp_ready  (ci_rsp_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are then driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-24s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue a command from IDLE; returns in REQ state with core_req_valid dropped.
    task automatic issue(input logic [7:0] op, input logic [63:0] a0, input logic [63:0] a1);
        core_req_valid = 1'b1;
        core_op        = op;
        core_arg0      = a0;
        core_arg1      = a1;
        chk("accept_ready", 64'(core_req_ready), 64'd1);
        step();
        core_req_valid = 1'b0;
        core_op        = 8'h00;
        core_arg0      = '0;
        core_arg1      = '0;
    endtask

    // Release a pending result and return to IDLE.
    task automatic retire();
        core_rsp_ready = 1'b1;
        step();
        core_rsp_ready = 1'b0;
        chk("back_to_idle", 64'(core_req_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; core_req_valid = 0; core_op = 0; core_arg0 = 0; core_arg1 = 0;
        core_rsp_ready = 0; ci_ready = 0; ci_rsp_valid = 0; ci_rsp_data = 0;
        step(); step();
        // reset values
        chk("rst_busy",       64'(busy),           64'd0);
        chk("rst_ci_valid",   64'(ci_valid),       64'd0);
        chk("rst_rsp_valid",  64'(core_rsp_valid), 64'd0);
        chk("rst_rsp_data",   core_rsp_data,       64'd0);
        chk("rst_ci_op",      64'(ci_op),          64'd0);
        rst = 1'b0;
        step();

        // Always-ready responder, minimum latency.
        ci_ready = 1'b1;
        issue(8'h05, 64'hA0, 64'hA1);
        chk("lat_c1_ci_valid", 64'(ci_valid), 64'd1);
        chk("lat_c1_ci_op",    64'(ci_op),    64'h05);
        chk("lat_c1_arg0",     ci_arg0,       64'hA0);
        chk("lat_c1_req_rdy",  64'(core_req_ready), 64'd0);
        step();
        chk("lat_c2_ci_valid", 64'(ci_valid),     64'd0);
        chk("lat_c2_rsp_rdy",  64'(ci_rsp_ready), 64'd1);
        ci_rsp_valid = 1'b1; ci_rsp_data = 64'h1234;
        step();
        ci_rsp_valid = 1'b0;
        chk("lat_c3_rsp_valid", 64'(core_rsp_valid), 64'd1);
        chk("lat_c3_rsp_data",  core_rsp_data,        64'h1234);
        chk("lat_c3_rsp_err",   64'(core_rsp_err),    64'd0);
        chk("lat_c3_ci_valid",  64'(ci_valid),        64'd0);
        retire();

        // Responder stalls ci_ready for 5 cycles.
        ci_ready = 1'b0;
        issue(8'h3C, 64'h1111_2222_3333_4444, 64'h5555);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ci_valid", 64'(ci_valid), 64'd1);
            chk("stall_ci_op",    64'(ci_op),    64'h3C);
            chk("stall_ci_arg0",  ci_arg0,       64'h1111_2222_3333_4444);
            chk("stall_ci_arg1",  ci_arg1,       64'h5555);
            step();
        end
        ci_ready = 1'b1;
        chk("stall_last_valid", 64'(ci_valid), 64'd1);
        step();
        ci_rsp_valid = 1'b1; ci_rsp_data = 64'hBEEF;
        step();
        ci_rsp_valid = 1'b0;
        chk("stall_rsp_valid", 64'(core_rsp_valid), 64'd1);
        chk("stall_rsp_data",  core_rsp_data,       64'hBEEF);
        retire();

        // Stub responder -> error flag, data passed through.
        issue(8'h07, 64'h1, 64'h2);
        step();
        ci_rsp_valid = 1'b1; ci_rsp_data = 64'hDEAD_DEAD_DEAD_0001;
        step();
        ci_rsp_valid = 1'b0;
        chk("stub_rsp_data", core_rsp_data,     64'hDEAD_DEAD_DEAD_0001);
        chk("stub_rsp_err",  64'(core_rsp_err), 64'd1);
        retire();

        // Timeout: responder never answers.
        issue(8'h09, 64'h3, 64'h4);
        n = 0;
        while (!core_rsp_valid && n < 20) begin
            n++;
            step();
        end
        chk("to_cycles",   64'(n),             64'd8);
        chk("to_rsp_data", core_rsp_data,      64'hDEAD_DEAD_DEAD_0002);
        chk("to_rsp_err",  64'(core_rsp_err),  64'd1);
        retire();
        // Late response drained in IDLE without touching outputs.
        ci_rsp_valid = 1'b1; ci_rsp_data = 64'h5A5A;
        chk("late_rsp_ready", 64'(ci_rsp_ready), 64'd1);
        step();
        ci_rsp_valid = 1'b0;
        chk("late_rsp_data",  core_rsp_data,        64'hDEAD_DEAD_DEAD_0002);
        chk("late_rsp_valid", 64'(core_rsp_valid),  64'd0);
        chk("late_busy",      64'(busy),            64'd0);

        // Handshake on the final allowed cycle beats the timeout.
        ci_ready = 1'b0;
        issue(8'h0A, 64'h5, 64'h6);
        for (int i = 0; i < 6; i++) step();
        ci_ready = 1'b1;
        step();
        ci_ready = 1'b0;
        ci_rsp_valid = 1'b1; ci_rsp_data = 64'h7777;
        step();
        ci_rsp_valid = 1'b0;
        ci_ready = 1'b1;
        chk("edge_rsp_valid", 64'(core_rsp_valid), 64'd1);
        chk("edge_rsp_data",  core_rsp_data,       64'h7777);
        chk("edge_rsp_err",   64'(core_rsp_err),   64'd0);
        retire();

        // Core back-pressure: result held, new command refused until IDLE.
        issue(8'h0B, 64'h8, 64'h9);
        step();
        ci_rsp_valid = 1'b1; ci_rsp_data = 64'hCAFE;
        step();
        ci_rsp_valid = 1'b0;
        core_req_valid = 1'b1; core_op = 8'h0C; core_arg0 = 64'hC0; core_arg1 = 64'hC1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid", 64'(core_rsp_valid), 64'd1);
            chk("bp_rsp_data",  core_rsp_data,       64'hCAFE);
            chk("bp_req_ready", 64'(core_req_ready), 64'd0);
            step();
        end
        core_rsp_ready = 1'b1;
        step();
        core_rsp_ready = 1'b0;
        chk("bp_idle_ready", 64'(core_req_ready), 64'd1);
        step();
        core_req_valid = 1'b0;
        chk("bp_next_op",   64'(ci_op),  64'h0C);
        chk("bp_next_arg1", ci_arg1,     64'hC1);
        step();
        ci_rsp_valid = 1'b1; ci_rsp_data = 64'hD00D;
        step();
        ci_rsp_valid = 1'b0;
        chk("bp_next_data", core_rsp_data, 64'hD00D);
        retire();

        // Reset mid-transaction in WAIT_RSP.
        issue(8'h0D, 64'hE0, 64'hE1);
        step();
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        chk("mrst_busy",      64'(busy),           64'd0);
        chk("mrst_rsp_valid", 64'(core_rsp_valid), 64'd0);
        chk("mrst_rsp_data",  core_rsp_data,       64'd0);
        chk("mrst_ci_op",     64'(ci_op),          64'd0);
        chk("mrst_ci_arg0",   ci_arg0,             64'd0);
        rst = 1'b0;
        step();
        chk("mrst_req_ready", 64'(core_req_ready), 64'd1);
        chk("mrst_no_rsp",    64'(core_rsp_valid), 64'd0);
        issue(8'h0E, 64'hF0, 64'hF1);
        step();
        ci_rsp_valid = 1'b1; ci_rsp_data = 64'h4242;
        step();
        ci_rsp_valid = 1'b0;
        chk("post_rst_data", core_rsp_data,     64'h4242);
        chk("post_rst_err",  64'(core_rsp_err), 64'd0);
        retire();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
